// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// multicycle_control_pkg -- states, instruction classes, opcodes, ALU codes
// Revision 1.0
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CL_NONE = 3'd0,
      CL_R    = 3'd1,
      CL_I    = 3'd2,
      CL_B    = 3'd3,
      CL_S    = 3'd4,
      CL_L    = 3'd5
   } iclass_t;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_L = 7'b0000011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_CMP = 4'b1111;

   function automatic iclass_t classify(input logic [6:0] op);
      case (op)
         OP_R:    return CL_R;
         OP_I:    return CL_I;
         OP_B:    return CL_B;
         OP_S:    return CL_S;
         OP_L:    return CL_L;
         default: return CL_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
// ============================================================================
// alu_decoder -- maps (class, funct3, funct7) to ALU code, operand select, legality
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_decoder
   import multicycle_control_pkg::*;
(
   input  logic [2:0] cls,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_code,
   output logic       alu_src_imm,
   output logic       legal
);

   always_comb begin
      alu_code    = ALU_ADD;
      alu_src_imm = 1'b0;
      legal       = 1'b0;
      case (cls)
         CL_R: begin
            case (funct3)
               3'b000: begin
                  if (funct7 == 7'b0000000) begin
                     legal = 1'b1;
                  end else if (funct7 == 7'b0100000) begin
                     alu_code = ALU_SUB;
                     legal    = 1'b1;
                  end
               end
               3'b111: begin
                  alu_code = ALU_AND;
                  legal    = 1'b1;
               end
               3'b110: begin
                  alu_code = ALU_OR;
                  legal    = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         CL_I: begin
            alu_src_imm = 1'b1;
            case (funct3)
               3'b000: legal = 1'b1;
               3'b111: begin
                  alu_code = ALU_AND;
                  legal    = 1'b1;
               end
               3'b110: begin
                  alu_code = ALU_OR;
                  legal    = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         CL_B: begin
            alu_code = ALU_CMP;
            legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
         end
         CL_S, CL_L: begin
            // Address generation: base + immediate
            alu_src_imm = 1'b1;
            legal       = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control -- multicycle CPU control FSM with memory timeout trap
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic                  pc_branch,
   output logic                  alu_src_imm,
   output logic                  mem_to_reg,
   output logic                  reg_write,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  trap,
   output logic [CNT_W-1:0]      instret
);

   // Counter spans 0..MEM_TIMEOUT-1; the last value is the final allowed cycle
   localparam int              WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   state_t            next_state;
   iclass_t           cls_r;
   iclass_t           dec_cls;
   logic [3:0]        alu_r;
   logic              imm_r;
   logic              bne_r;
   logic [3:0]        dec_code;
   logic              dec_imm;
   logic              dec_legal;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_done;
   logic              retire;

   assign dec_cls = classify(opcode);

   alu_decoder u_alu_decoder (
      .cls         (dec_cls),
      .funct3      (funct3),
      .funct7      (funct7),
      .alu_code    (dec_code),
      .alu_src_imm (dec_imm),
      .legal       (dec_legal)
   );

   assign wait_done = (wait_cnt == WAIT_LAST);

   assign retire = (state == ST_WB) ||
                   ((state == ST_EXEC) && (cls_r == CL_B)) ||
                   ((state == ST_MEM) && (cls_r == CL_S) && mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   next_state = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready)      next_state = ST_DECODE;
            else if (wait_done) next_state = ST_TRAP;
         end
         ST_DECODE: next_state = dec_legal ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            case (cls_r)
               CL_R, CL_I: next_state = ST_WB;
               CL_S, CL_L: next_state = ST_MEM;
               CL_B:       next_state = ST_FETCH;
               default:    next_state = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (mem_ready)      next_state = (cls_r == CL_L) ? ST_WB : ST_FETCH;
            else if (wait_done) next_state = ST_TRAP;
         end
         ST_WB:     next_state = ST_FETCH;
         ST_TRAP:   next_state = ST_TRAP;
         default:   next_state = ST_TRAP;
      endcase
   end

   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_branch   = 1'b0;
      alu_src_imm = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_control = '0;
      trap        = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         ST_EXEC: begin
            alu_control = ALU_CTRL_W'(alu_r);
            alu_src_imm = imm_r;
            if (cls_r == CL_B) begin
               pc_branch = bne_r ? !zero : zero;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls_r == CL_S);
         end
         ST_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (cls_r == CL_L);
         end
         ST_TRAP:  trap = 1'b1;
         default:  trap = 1'b0;
      endcase
   end

   // Decode results are captured once so later stages ignore IR changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_r <= CL_NONE;
         alu_r <= ALU_ADD;
         imm_r <= 1'b0;
         bne_r <= 1'b0;
      end else if (state == ST_DECODE) begin
         cls_r <= dec_cls;
         alu_r <= dec_code;
         imm_r <= dec_imm;
         bne_r <= funct3[0];
      end
   end

   // Any exit from FETCH/MEM leaves the counter cleared for the next entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (((state == ST_FETCH) || (state == ST_MEM)) && (next_state == state)) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control -- directed self-checking bench for multicycle_control
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        ir_write;
   logic        pc_write;
   logic        pc_branch;
   logic        alu_src_imm;
   logic        mem_to_reg;
   logic        reg_write;
   logic [3:0]  alu_control;
   logic        trap;
   logic [31:0] instret;
   logic [12:0] ctl;

   int checks   = 0;
   int failures = 0;

   multicycle_control #(
      .ALU_CTRL_W  (4),
      .MEM_TIMEOUT (16),
      .CNT_W       (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_branch   (pc_branch),
      .alu_src_imm (alu_src_imm),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .alu_control (alu_control),
      .trap        (trap),
      .instret     (instret)
   );

   assign ctl = {mem_req, mem_we, ir_write, pc_write, pc_branch, alu_src_imm,
                 mem_to_reg, reg_write, alu_control, trap};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opcode = op;
      funct3 = f3;
      funct7 = f7;
   endtask

   // Leaves the DUT at the negedge of its first FETCH cycle
   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // From a FETCH negedge: instant fetch, decode, arrive at the EXEC negedge
   task automatic fetch_decode();
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== 13'h0 || instret !== 32'd0 || dut.state !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_hold: ctl=%h instret=%0d state=%0d, want 0/0/IDLE", ctl, instret, dut.state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || dut.state !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_idle: mem_req=%b state=%0d, want 0/IDLE", mem_req, dut.state);
      end
      @(negedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || dut.state !== ST_FETCH) begin
         failures++;
         $display("FAIL reset_first_fetch: mem_req=%b mem_we=%b state=%0d, want 1/0/FETCH", mem_req, mem_we, dut.state);
      end
   endtask

   task automatic test_add();
      do_reset();
      set_instr(OP_R, 3'b000, 7'b0000000);
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({mem_req, mem_we, ir_write, pc_write} !== 4'b1011) begin
         failures++;
         $display("FAIL add_fetch: req/we/ir/pc=%b, want 1011", {mem_req, mem_we, ir_write, pc_write});
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (dut.state !== ST_DECODE || ctl !== 13'h0) begin
         failures++;
         $display("FAIL add_decode: state=%0d ctl=%h, want DECODE/0", dut.state, ctl);
      end
      @(negedge clk);
      #1;
      checks++;
      if (dut.state !== ST_EXEC || alu_control !== 4'b0000 || alu_src_imm !== 1'b0 || reg_write !== 1'b0) begin
         failures++;
         $display("FAIL add_exec: state=%0d alu=%b imm=%b rw=%b, want EXEC/0000/0/0", dut.state, alu_control, alu_src_imm, reg_write);
      end
      @(negedge clk);
      #1;
      checks++;
      if (dut.state !== ST_WB || reg_write !== 1'b1 || mem_to_reg !== 1'b0 || instret !== 32'd0) begin
         failures++;
         $display("FAIL add_wb: state=%0d rw=%b m2r=%b instret=%0d, want WB/1/0/0", dut.state, reg_write, mem_to_reg, instret);
      end
      @(negedge clk);
      #1;
      checks++;
      if (dut.state !== ST_FETCH || instret !== 32'd1 || reg_write !== 1'b0) begin
         failures++;
         $display("FAIL add_retire: state=%0d instret=%0d rw=%b, want FETCH/1/0", dut.state, instret, reg_write);
      end
   endtask

   task automatic test_alu_ops();
      logic [6:0] ops  [4] = '{OP_R, OP_R, OP_I, OP_I};
      logic [2:0] f3s  [4] = '{3'b000, 3'b111, 3'b110, 3'b000};
      logic [6:0] f7s  [4] = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0100000};
      logic [3:0] alus [4] = '{4'b0001, 4'b0010, 4'b0011, 4'b0000};
      logic       imms [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         do_reset();
         set_instr(ops[i], f3s[i], f7s[i]);
         fetch_decode();
         #1;
         checks++;
         if (dut.state !== ST_EXEC || alu_control !== alus[i] || alu_src_imm !== imms[i]) begin
            failures++;
            $display("FAIL alu_op[%0d]: state=%0d alu=%b imm=%b, want EXEC/%b/%b", i, dut.state, alu_control, alu_src_imm, alus[i], imms[i]);
         end
      end
   endtask

   task automatic test_branch();
      do_reset();
      set_instr(OP_B, 3'b001, 7'b0000000);
      fetch_decode();
      zero = 1'b0;
      #1;
      checks++;
      if (pc_branch !== 1'b1 || alu_control !== 4'b1111) begin
         failures++;
         $display("FAIL bne_taken: pc_branch=%b alu=%b, want 1/1111", pc_branch, alu_control);
      end
      @(negedge clk);
      #1;
      checks++;
      if (dut.state !== ST_FETCH || instret !== 32'd1) begin
         failures++;
         $display("FAIL bne_taken_retire: state=%0d instret=%0d, want FETCH/1", dut.state, instret);
      end
      fetch_decode();
      zero = 1'b1;
      #1;
      checks++;
      if (pc_branch !== 1'b0 || dut.state !== ST_EXEC) begin
         failures++;
         $display("FAIL bne_not_taken: pc_branch=%b state=%0d, want 0/EXEC", pc_branch, dut.state);
      end
      @(negedge clk);
      #1;
      checks++;
      if (instret !== 32'd2) begin
         failures++;
         $display("FAIL bne_not_taken_retire: instret=%0d, want 2", instret);
      end
      set_instr(OP_B, 3'b000, 7'b0000000);
      fetch_decode();
      zero = 1'b1;
      #1;
      checks++;
      if (pc_branch !== 1'b1) begin
         failures++;
         $display("FAIL beq_taken: pc_branch=%b, want 1", pc_branch);
      end
      zero = 1'b0;
   endtask

   task automatic test_load();
      int n;
      do_reset();
      set_instr(OP_L, 3'b001, 7'b0000000);
      fetch_decode();
      #1;
      checks++;
      if (alu_control !== 4'b0000 || alu_src_imm !== 1'b1) begin
         failures++;
         $display("FAIL lh_exec: alu=%b imm=%b, want 0000/1", alu_control, alu_src_imm);
      end
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_ready = (i == 3);
         #1;
         if (mem_req && !mem_we && dut.state == ST_MEM) n++;
      end
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL lh_mem_wait: read-request cycles=%0d, want 4", n);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (dut.state !== ST_WB || reg_write !== 1'b1 || mem_to_reg !== 1'b1 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL lh_wb: state=%0d rw=%b m2r=%b req=%b, want WB/1/1/0", dut.state, reg_write, mem_to_reg, mem_req);
      end
      @(negedge clk);
      #1;
      checks++;
      if (instret !== 32'd1) begin
         failures++;
         $display("FAIL lh_retire: instret=%0d, want 1", instret);
      end
   endtask

   task automatic test_store();
      logic rw_seen;
      do_reset();
      set_instr(OP_S, 3'b001, 7'b0000000);
      fetch_decode();
      #1;
      rw_seen = reg_write;
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      rw_seen = rw_seen | reg_write;
      checks++;
      if ({mem_req, mem_we} !== 2'b11 || dut.state !== ST_MEM) begin
         failures++;
         $display("FAIL sh_mem: req/we=%b state=%0d, want 11/MEM", {mem_req, mem_we}, dut.state);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      rw_seen = rw_seen | reg_write;
      checks++;
      if (dut.state !== ST_FETCH || rw_seen !== 1'b0 || instret !== 32'd1) begin
         failures++;
         $display("FAIL sh_retire: state=%0d rw_seen=%b instret=%0d, want FETCH/0/1", dut.state, rw_seen, instret);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      repeat (15) @(negedge clk);
      #1;
      checks++;
      if (dut.state !== ST_FETCH || trap !== 1'b0) begin
         failures++;
         $display("FAIL fetch_before_limit: state=%0d trap=%b, want FETCH/0", dut.state, trap);
      end
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== 13'h0001) begin
         failures++;
         $display("FAIL fetch_timeout: ctl=%h, want 0001 (trap only)", ctl);
      end
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (trap !== 1'b1 || ir_write !== 1'b0) begin
         failures++;
         $display("FAIL trap_sticky: trap=%b ir_write=%b, want 1/0", trap, ir_write);
      end
      do_reset();
      repeat (15) @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++;
      if (ir_write !== 1'b1 || trap !== 1'b0) begin
         failures++;
         $display("FAIL fetch_at_limit: ir_write=%b trap=%b, want 1/0", ir_write, trap);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (dut.state !== ST_DECODE || trap !== 1'b0) begin
         failures++;
         $display("FAIL fetch_at_limit_next: state=%0d trap=%b, want DECODE/0", dut.state, trap);
      end
      do_reset();
      set_instr(OP_L, 3'b010, 7'b0000000);
      fetch_decode();
      repeat (16) @(negedge clk);
      #1;
      checks++;
      if (dut.state !== ST_MEM || trap !== 1'b0) begin
         failures++;
         $display("FAIL mem_before_limit: state=%0d trap=%b, want MEM/0", dut.state, trap);
      end
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== 13'h0001) begin
         failures++;
         $display("FAIL mem_timeout: ctl=%h, want 0001 (trap only)", ctl);
      end
   endtask

   task automatic test_illegal();
      logic [6:0] ops [3] = '{7'b1111111, OP_R, OP_B};
      logic [2:0] f3s [3] = '{3'b000, 3'b000, 3'b010};
      logic [6:0] f7s [3] = '{7'b0000000, 7'b0000001, 7'b0000000};
      for (int i = 0; i < 3; i++) begin
         do_reset();
         set_instr(ops[i], f3s[i], f7s[i]);
         fetch_decode();
         #1;
         checks++;
         if (ctl !== 13'h0001 || dut.state !== ST_TRAP) begin
            failures++;
            $display("FAIL illegal[%0d]: ctl=%h state=%0d, want 0001/TRAP", i, ctl, dut.state);
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      set_instr(OP_R, 3'b000, 7'b0000000);
      fetch_decode();
      @(negedge clk);
      @(negedge clk);
      set_instr(OP_L, 3'b000, 7'b0000000);
      fetch_decode();
      @(negedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || dut.state !== ST_MEM || instret !== 32'd1) begin
         failures++;
         $display("FAIL pre_reset_mem: req=%b state=%0d instret=%0d, want 1/MEM/1", mem_req, dut.state, instret);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctl !== 13'h0 || instret !== 32'd0 || dut.state !== ST_IDLE) begin
         failures++;
         $display("FAIL async_reset: ctl=%h instret=%0d state=%0d, want 0/0/IDLE", ctl, instret, dut.state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (dut.state !== ST_IDLE || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL restart_idle: state=%0d req=%b, want IDLE/0", dut.state, mem_req);
      end
      @(negedge clk);
      #1;
      checks++;
      if (dut.state !== ST_FETCH || mem_req !== 1'b1) begin
         failures++;
         $display("FAIL restart_fetch: state=%0d req=%b, want FETCH/1", dut.state, mem_req);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      opcode    = 7'b0;
      funct3    = 3'b0;
      funct7    = 7'b0;
      test_reset();
      test_add();
      test_alu_ops();
      test_branch();
      test_load();
      test_store();
      test_timeout();
      test_illegal();
      test_reset_mid_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
